mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive data-port grants allowed while a fetch request waits.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; held with if_addr until if_gnt.
REQ-005 if_addr  in  32  fetch address.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  out  32  fetched instruction word.
REQ-009 d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_gnt.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr  in  32  data address.
REQ-012 d_wdata  in  32  store data.
REQ-013 d_gnt  out  1  data request accepted this cycle.
REQ-014 d_rvalid  out  1  one-cycle pulse; load data valid, or store complete.
REQ-015 d_rdata  out  32  load data.
REQ-016 mem_req  out  1  request to the shared single-port memory.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_addr  out  32  memory address.
REQ-019 mem_wdata  out  32  memory write data.
REQ-020 mem_rvalid  in  1  memory response pulse, for read or write, 1+ cycles after mem_req.
REQ-021 mem_rdata  in  32  memory read data, valid with mem_rvalid.

Function
REQ-022 FSM states: IDLE, WAIT_I, WAIT_D; at most one memory transaction outstanding.
REQ-023 IDLE, requests present: exactly one of if_gnt/d_gnt is asserted combinationally in the same cycle.
- mem_req = if_gnt | d_gnt.
- mem_addr/mem_we/mem_wdata are muxed from the granted port.
- On a fetch grant, mem_we = 0 and mem_wdata = 0.
REQ-024 Priority: data port wins when both request, except when starve_cnt == STARVE_MAX; then the fetch port wins.
REQ-025 starve_cnt (3 bits, saturating): increments on each d_gnt issued while if_req = 1; clears on if_gnt.
REQ-026 Transitions:
- IDLE -> WAIT_I on if_gnt; IDLE -> WAIT_D on d_gnt.
- WAIT_x -> IDLE on mem_rvalid.
- No grant is issued in WAIT states, so the earliest next grant is the cycle after mem_rvalid.
REQ-027 In WAIT_I, mem_rvalid produces if_rvalid = 1 and if_rdata = mem_rdata in the same cycle (combinational route).
REQ-028 In WAIT_D, mem_rvalid produces d_rvalid = 1 and d_rdata = mem_rdata; for a store the d_rdata value is don't-care.
REQ-029 Outside the active WAIT state, the rvalid outputs are 0 and the rdata outputs are 0.
REQ-030 mem_rvalid in IDLE is ignored: no rvalid pulse, no state change.
REQ-031 Requests deasserted or changed during a WAIT state are ignored; the owner of the outstanding transaction does not change.
REQ-032 Throughput: with 1-cycle memory latency, one transaction completes every 2 cycles.

Reset
REQ-033 On rst_n low, asynchronously: state = IDLE, starve_cnt = 0.
- All gnt, rvalid and mem_req outputs are 0.
- All rdata and mem_* data/address outputs are 0.
REQ-034 Reset mid-transaction abandons the transaction; a later mem_rvalid is ignored per REQ-030.

Structure
REQ-035 State encoding and the STARVE_MAX default live in the shared core package, alongside the existing pipeline constants.
REQ-036 Single module; no sub-module: the FSM, counter and muxes are too small to justify one.

Verification
REQ-037 Fetch only, memory latency 1: if_req, if_addr = 0x100, memory returns 0x00A00093 -> if_gnt in cycle 0, if_rvalid with 0x00A00093 in cycle 1, next if_gnt in cycle 2.
REQ-038 Simultaneous if_req and d_req (load at 0x2000) -> d_gnt first, d_rvalid, then if_gnt on the following IDLE cycle.
REQ-039 d_req and if_req held continuously -> exactly 4 d_gnt, then 1 if_gnt, then starve_cnt reads 0 and the pattern repeats.
REQ-040 Store d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF -> mem_we = 1, mem_wdata = 0xDEADBEEF in the grant cycle; d_rvalid on ack; if_rvalid stays 0.
REQ-041 Latency 3, rst_n pulsed low in WAIT_D -> all outputs 0 immediately; the late mem_rvalid produces no d_rvalid; the next if_req is granted normally.
REQ-042 Spurious mem_rvalid in IDLE with no requests -> no rvalid pulse, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared core constants: pipeline widths and arbiter state/starvation settings.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned ILEN           = 32;
    localparam int unsigned STARVE_W       = 3;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_I = 2'd1,
        ARB_WAIT_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory, one transaction in flight,
// data-first with a bounded starvation window for fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [ILEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

    arb_state_e          state;
    arb_state_e          state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                idle;
    logic                fetch_wins;
    mem_cmd_t            cmd;

    // Grants, memory mux and response routing; grants are gated by rst_n so reset clears them at once.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        cmd        = '0;
        idle       = rst_n && (state == ARB_IDLE);
        fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_LIM));

        if_gnt     = idle && fetch_wins;
        d_gnt      = idle && d_req && !fetch_wins;
        mem_req    = if_gnt || d_gnt;

        if (if_gnt) begin
            cmd.addr = if_addr;
        end else if (d_gnt) begin
            cmd.we    = d_we;
            cmd.addr  = d_addr;
            cmd.wdata = d_wdata;
        end
        mem_we    = cmd.we;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;

        if_rvalid = rst_n && (state == ARB_WAIT_I) && mem_rvalid;
        d_rvalid  = rst_n && (state == ARB_WAIT_D) && mem_rvalid;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid  ? mem_rdata : '0;

        unique case (state)
            ARB_IDLE: begin
                if (if_gnt) begin
                    state_nxt = ARB_WAIT_I;
                end else if (d_gnt) begin
                    state_nxt = ARB_WAIT_D;
                end
            end
            ARB_WAIT_I, ARB_WAIT_D: begin
                if (mem_rvalid) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase

        // Count data wins that made a waiting fetch wait longer; a fetch grant resets the window.
        if (if_gnt) begin
            starve_nxt = '0;
        end else if (d_gnt && if_req && (starve_cnt != STARVE_SAT)) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand sequences, random traffic vs model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_d_rvalid;
        logic [31:0] e_d_rdata;
    } vec_t;

    function automatic vec_t v(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic mrv, input logic [31:0] mrd,
                               input logic eig, input logic edg, input logic ewe,
                               input logic [31:0] ema, input logic [31:0] emw,
                               input logic eirv, input logic [31:0] eird,
                               input logic edrv, input logic [31:0] edrd);
        vec_t t;
        t.rst_n = r; t.if_req = ir; t.if_addr = ia;
        t.d_req = dr; t.d_we = dw; t.d_addr = da; t.d_wdata = dwd;
        t.mem_rvalid = mrv; t.mem_rdata = mrd;
        t.e_if_gnt = eig; t.e_d_gnt = edg; t.e_mem_we = ewe;
        t.e_mem_addr = ema; t.e_mem_wdata = emw;
        t.e_if_rvalid = eirv; t.e_if_rdata = eird;
        t.e_d_rvalid = edrv; t.e_d_rdata = edrd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic eig, input logic edg, input logic ewe,
                               input logic [31:0] ema, input logic [31:0] emw,
                               input logic eirv, input logic [31:0] eird,
                               input logic edrv, input logic [31:0] edrd, input bit chk_drd);
        chk({tag, ".if_gnt"},    32'(if_gnt),    32'(eig));
        chk({tag, ".d_gnt"},     32'(d_gnt),     32'(edg));
        chk({tag, ".mem_req"},   32'(mem_req),   32'(eig | edg));
        chk({tag, ".mem_we"},    32'(mem_we),    32'(ewe));
        chk({tag, ".mem_addr"},  mem_addr,       ema);
        chk({tag, ".mem_wdata"}, mem_wdata,      emw);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(eirv));
        chk({tag, ".if_rdata"},  if_rdata,       eird);
        chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'(edrv));
        if (chk_drd) chk({tag, ".d_rdata"}, d_rdata, edrd);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    vec_t vecs[$];

    // Reference model state for random traffic: owner of the outstanding access and starvation count.
    int          ref_owner;
    int          ref_starve;
    bit          ref_store;
    bit          mem_busy;
    int          mem_cnt;
    bit          if_act;
    bit          d_act;
    logic        e_ig, e_dg, e_we, e_irv, e_drv;
    logic [31:0] e_ma, e_mw, e_ird, e_drd;

    initial begin
        rst_n = 0;
        idle_inputs();

        // Directed table, memory latency 1 driven straight from the vectors.
        vecs.push_back(v(0, 1,32'h100, 1,0,32'h2000,32'h0, 1,32'h77,        0,0,0,32'h0,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 1,32'h100, 0,0,32'h0,32'h0,    0,32'h0,         1,0,0,32'h100,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 1,32'h100, 0,0,32'h0,32'h0,    1,32'h00A00093,  0,0,0,32'h0,32'h0, 1,32'h00A00093, 0,32'h0));
        vecs.push_back(v(1, 1,32'h100, 0,0,32'h0,32'h0,    0,32'h0,         1,0,0,32'h100,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 1,32'h104, 0,0,32'h0,32'h0,    1,32'h11,        0,0,0,32'h0,32'h0, 1,32'h11, 0,32'h0));
        vecs.push_back(v(1, 1,32'h104, 1,0,32'h2000,32'h12345678, 0,32'h0,  0,1,0,32'h2000,32'h12345678, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 1,32'h104, 0,0,32'h0,32'h0,    1,32'hCAFEF00D,  0,0,0,32'h0,32'h0, 0,32'h0, 1,32'hCAFEF00D));
        vecs.push_back(v(1, 1,32'h104, 0,0,32'h0,32'h0,    0,32'h0,         1,0,0,32'h104,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   0,0,32'h0,32'h0,    1,32'h22,        0,0,0,32'h0,32'h0, 1,32'h22, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   1,1,32'h40,32'hDEADBEEF, 0,32'h0,    0,1,1,32'h40,32'hDEADBEEF, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   0,0,32'h0,32'h0,    1,32'h0,         0,0,0,32'h0,32'h0, 0,32'h0, 1,32'h0));
        vecs.push_back(v(1, 0,32'h0,   0,0,32'h0,32'h0,    1,32'h55,        0,0,0,32'h0,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   0,0,32'h0,32'h0,    0,32'h0,         0,0,0,32'h0,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 1,32'h200, 0,0,32'h0,32'h0,    0,32'h0,         1,0,0,32'h200,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   1,0,32'h44,32'h0,   0,32'h0,         0,0,0,32'h0,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   1,0,32'h44,32'h0,   1,32'h33,        0,0,0,32'h0,32'h0, 1,32'h33, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   1,0,32'h44,32'h0,   0,32'h0,         0,1,0,32'h44,32'h0, 0,32'h0, 0,32'h0));
        vecs.push_back(v(1, 0,32'h0,   0,0,32'h0,32'h0,    1,32'h44,        0,0,0,32'h0,32'h0, 0,32'h0, 1,32'h44));

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            mem_rvalid = vecs[i].mem_rvalid; mem_rdata = vecs[i].mem_rdata;
            @(negedge clk);
            chk_outputs($sformatf("vec%0d", i), vecs[i].e_if_gnt, vecs[i].e_d_gnt, vecs[i].e_mem_we,
                        vecs[i].e_mem_addr, vecs[i].e_mem_wdata, vecs[i].e_if_rvalid,
                        vecs[i].e_if_rdata, vecs[i].e_d_rvalid, vecs[i].e_d_rdata, 1'b1);
            @(posedge clk); #1;
        end

        // Both ports held: four data grants, then one fetch grant, repeating.
        idle_inputs();
        if_req = 1; d_req = 1;
        for (int k = 0; k < 20; k++) begin
            bit exp_i;
            exp_i = (k % (STARVE_MAX + 1)) == STARVE_MAX;
            if_addr = 32'h1000 + 32'(k * 4);
            d_addr  = 32'h3000 + 32'(k * 4);
            mem_rvalid = 0;
            @(negedge clk);
            chk($sformatf("starve%0d.if_gnt", k), 32'(if_gnt), 32'(exp_i));
            chk($sformatf("starve%0d.d_gnt", k),  32'(d_gnt),  32'(!exp_i));
            @(posedge clk); #1;
            mem_rvalid = 1; mem_rdata = 32'hA000 + 32'(k);
            @(negedge clk);
            chk($sformatf("starve%0d.wait_gnt", k), 32'({if_gnt, d_gnt}), 32'h0);
            chk($sformatf("starve%0d.rvalid", k), 32'({if_rvalid, d_rvalid}), exp_i ? 32'h2 : 32'h1);
            if (exp_i) chk($sformatf("starve%0d.cnt", k), 32'(dut.starve_cnt), 32'h0);
            @(posedge clk); #1;
        end

        // Reset pulsed while a latency-3 load is outstanding.
        idle_inputs();
        if_req = 1; if_addr = 32'h500; d_req = 1; d_addr = 32'h300;
        @(negedge clk);
        chk("rst.d_gnt", 32'(d_gnt), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst.wait_gnt", 32'({if_gnt, d_gnt}), 32'h0);
        @(posedge clk); #2;
        rst_n = 0; mem_rdata = 32'h1234;
        #1;
        chk_outputs("rst.async", 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1);
        if_req = 0; d_req = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        mem_rvalid = 1; mem_rdata = 32'h5151;
        @(negedge clk);
        chk_outputs("rst.late", 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1);
        @(posedge clk); #1;
        mem_rvalid = 0; if_req = 1; if_addr = 32'h400;
        @(negedge clk);
        chk_outputs("rst.next", 1, 0, 0, 32'h400, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1);
        @(posedge clk); #1;
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h0BADC0DE;
        @(negedge clk);
        chk_outputs("rst.next_ack", 0, 0, 0, 32'h0, 32'h0, 1, 32'h0BADC0DE, 0, 32'h0, 1'b1);
        @(posedge clk); #1;

        // Random traffic with random latency and spurious responses against the model.
        idle_inputs();
        ref_owner = 0; ref_starve = 0; ref_store = 0;
        mem_busy = 0; mem_cnt = 0; if_act = 0; d_act = 0;
        for (int c = 0; c < 600; c++) begin
            mem_rdata = $urandom;
            if (mem_busy) begin
                mem_cnt--;
                mem_rvalid = (mem_cnt == 0);
                if (mem_cnt == 0) mem_busy = 0;
            end else begin
                mem_rvalid = (ref_owner == 0) && ($urandom_range(0, 7) == 0);
            end
            if (if_act && ref_owner != 0 && $urandom_range(0, 7) == 0) if_act = 0;
            if (d_act && ref_owner != 0 && $urandom_range(0, 7) == 0) d_act = 0;
            if (!if_act && $urandom_range(0, 2) != 0) begin
                if_act = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_act && $urandom_range(0, 2) != 0) begin
                d_act = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            if_req = if_act; d_req = d_act;

            e_ig = 0; e_dg = 0; e_we = 0; e_ma = 0; e_mw = 0;
            e_irv = 0; e_ird = 0; e_drv = 0; e_drd = 0;
            if (ref_owner == 0) begin
                if (if_req && (!d_req || ref_starve == STARVE_MAX)) begin
                    e_ig = 1; e_ma = if_addr;
                end else if (d_req) begin
                    e_dg = 1; e_we = d_we; e_ma = d_addr; e_mw = d_wdata;
                end
            end else if (mem_rvalid) begin
                if (ref_owner == 1) begin
                    e_irv = 1; e_ird = mem_rdata;
                end else begin
                    e_drv = 1; e_drd = mem_rdata;
                end
            end

            @(negedge clk);
            chk_outputs($sformatf("rnd%0d", c), e_ig, e_dg, e_we, e_ma, e_mw,
                        e_irv, e_ird, e_drv, e_drd, !(e_drv && ref_store));

            if (e_ig) begin
                ref_owner = 1; ref_starve = 0; if_act = 0;
                mem_busy = 1; mem_cnt = $urandom_range(1, 3);
            end else if (e_dg) begin
                ref_owner = 2; ref_store = d_we; d_act = 0;
                if (if_req && ref_starve < 7) ref_starve++;
                mem_busy = 1; mem_cnt = $urandom_range(1, 3);
            end else if (ref_owner != 0 && mem_rvalid) begin
                ref_owner = 0;
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
